mem_port_arbiter: RTL
=====================

Name: mem_port_arbiter

Overview:
- Two-requester arbiter/sequencer in front of the 256x8 byte RAM and its MOV/MOC handshake.
- Shares the single RAM port between the instruction-fetch path (I) and the load/store data path (D).
- Issues one operation at a time, holds MOV until MOC, captures read data and returns a one-cycle ACK to the winning requester.
- Sits between the CPU control unit and the RAM top level.

Parameters:
- FETCH_MS, 3'b010, MS_2_0 code driven for every instruction fetch (word, unsigned).
- TIMEOUT_CYCLES, 255, number of WAIT cycles without MOC before abort (feature only).
- CNT_W, 8, width of the timeout counter; must hold TIMEOUT_CYCLES.

Ports:
- CLK  in  1  system clock, rising edge.
- RESET  in  1  asynchronous, active-low reset.
- I_REQ  in  1  fetch request, level.
- I_ADDR  in  32  fetch address.
- I_ACK  out  1  one-cycle fetch completion.
- I_RDATA  out  32  fetch data, valid with I_ACK.
- D_REQ  in  1  data request, level.
- D_RW  in  1  1 = read, 0 = write (RAM ReadWrite encoding).
- D_MS  in  3  size/sign code for the data access.
- D_ADDR  in  32  data address.
- D_WDATA  in  32  store data.
- D_ACK  out  1  one-cycle data completion.
- D_RDATA  out  32  load data, valid with D_ACK when D_RW = 1.
- MOV  out  1  to RAM: operation active.
- ReadWrite  out  1  to RAM.
- MS_2_0  out  3  to RAM.
- RAM_DIN  out  32  to RAM DataIn.
- RAM_ADDR  out  32  to RAM Address.
- MOC  in  1  from RAM: operation complete.
- RAM_DOUT  in  32  from RAM DataOut.
- ERR  out  1  one-cycle abort flag, coincident with ACK.

Behaviour:
- **Reset.** RESET low forces, asynchronously:
  - state IDLE;
  - all outputs 0;
  - last_grant = I, so D wins the first contention;
  - timeout counter 0.
- **Reset mid-operation.** The access is abandoned, MOV drops immediately, no ACK is issued, and there is no replay after reset.
- **Requester rules.**
  - The requester holds REQ and its address/data/control stable until its ACK.
  - REQ still high on the cycle after ACK is treated as a new request.
  - Fetch always drives ReadWrite = 1 and MS_2_0 = FETCH_MS.
- **IDLE.**
  - No request: MOV = 0 and state stays IDLE.
  - One request: grant it.
  - Both requests: grant the one that is not last_grant (round-robin).
  - On grant: register ADDR/WDATA/RW/MS into the RAM output registers, set MOV = 1, update last_grant, go to WAIT.
  - MOV is therefore high on the cycle after REQ is sampled.
- **WAIT.**
  - MOV and all RAM outputs are held constant.
  - When MOC is sampled 1: capture RAM_DOUT into the granted RDATA register, drop MOV, go to RESP.
- **RESP.**
  - The granted ACK is high for exactly one cycle.
  - RDATA holds its value until the next ACK to the same port.
  - D_RDATA is not updated on writes.
  - Next state is RELEASE.
- **RELEASE.**
  - Wait until MOC is sampled 0 (the RAM clears MOC after MOV falls), then go to IDLE.
  - A request arriving during RELEASE is held off.
- **Latency.** Minimum from REQ sampled to ACK is 3 cycles plus RAM MOC delay; no back-to-back issue without passing through RELEASE.
- **ACK exclusivity.** I_ACK and D_ACK are never high on the same cycle.
- **Simultaneous requests.** A request arriving while the other port is being serviced is served next. No starvation: with both requests held continuously, grants alternate I, D, I, D.
- **ERR.** 0 at all times unless the optional feature fires.

Optional Feature:
- Macro: MEM_TIMEOUT_EN.
- Defined:
  - The CNT_W counter clears on entry to WAIT and increments each WAIT cycle while MOC = 0.
  - When it reaches TIMEOUT_CYCLES: MOV drops, the next state is RESP, the granted ACK and ERR pulse together, and RDATA is loaded with 32'h0.
  - If MOC and timeout coincide, MOC wins: normal completion, ERR = 0.
- Undefined: no counter; WAIT lasts indefinitely; ERR is tied to 0.

Test Plan:
- **Single fetch.** I_REQ = 1, I_ADDR = 0x10; RAM returns MOC after 2 cycles with 0xE3A01005. Expect:
  - MOV = 1, ReadWrite = 1, MS_2_0 = 010, RAM_ADDR = 0x10 one cycle after REQ;
  - I_ACK pulse with I_RDATA = 0xE3A01005;
  - D_ACK stays 0.
- **Store byte.** D_REQ = 1, D_RW = 0, D_MS = 000, D_ADDR = 0x20, D_WDATA = 0xAB. Expect:
  - ReadWrite = 0, RAM_DIN = 0xAB;
  - D_ACK pulse;
  - D_RDATA unchanged;
  - then a load from 0x20 returns 0xAB on D_RDATA.
- **Contention from reset.** I_REQ and D_REQ rise together and are held for 4 transactions. Expect grant order D, I, D, I and never both ACKs in the same cycle.
- **Reset mid-access.** RESET driven low during WAIT. Expect:
  - MOV = 0 immediately (before the next CLK edge);
  - no ACK;
  - after release, the held I_REQ is serviced normally.
- **Timeout (MEM_TIMEOUT_EN, TIMEOUT_CYCLES = 4).** MOC held 0. Expect:
  - MOV drops after 4 WAIT cycles;
  - I_ACK = 1 and ERR = 1 in the same cycle;
  - I_RDATA = 0.
  - Without the macro: MOV stays high for 50+ cycles and ERR stays 0.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares the single MOV/MOC RAM port between the
// instruction-fetch requester (I) and the load/store requester (D).
// Only one operation is in flight at a time. With both requesters active,
// grants alternate round-robin; D wins the first contention after reset.
// Optional build macro MEM_TIMEOUT_EN aborts a WAIT that sees no MOC within
// TIMEOUT_CYCLES cycles and flags it on ERR alongside the ACK.
`timescale 1ns/1ps

module mem_port_arbiter #(
  parameter logic [2:0]  FETCH_MS       = 3'b010,
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter int unsigned CNT_W          = 8
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        I_REQ,
  input  logic [31:0] I_ADDR,
  output logic        I_ACK,
  output logic [31:0] I_RDATA,
  input  logic        D_REQ,
  input  logic        D_RW,
  input  logic [2:0]  D_MS,
  input  logic [31:0] D_ADDR,
  input  logic [31:0] D_WDATA,
  output logic        D_ACK,
  output logic [31:0] D_RDATA,
  output logic        MOV,
  output logic        ReadWrite,
  output logic [2:0]  MS_2_0,
  output logic [31:0] RAM_DIN,
  output logic [31:0] RAM_ADDR,
  input  logic        MOC,
  input  logic [31:0] RAM_DOUT,
  output logic        ERR
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_RESP,
    S_RELEASE
  } state_t;

  state_t      state, state_nx;

  logic        gnt_d;      // owner of the current operation: 1 = D, 0 = I
  logic        last_d;     // owner of the most recent grant: 1 = D, 0 = I
  logic        mov_q;
  logic        rw_q;
  logic [2:0]  ms_q;
  logic [31:0] din_q;
  logic [31:0] addr_q;
  logic [31:0] i_rdata_q;
  logic [31:0] d_rdata_q;

  logic        grant_i;
  logic        grant_d;
  logic        capture;
  logic        abort;

  // The timeout counter must be able to hold TIMEOUT_CYCLES.
  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES >= (64'd1 << CNT_W)) begin : g_cfg_check
    $error("mem_port_arbiter: TIMEOUT_CYCLES does not fit in CNT_W bits");
  end

`ifdef MEM_TIMEOUT_EN
  logic [CNT_W-1:0] cnt_q;
  logic             err_q;
  logic             timeout_hit;

  // The WAIT cycle that would take the count to TIMEOUT_CYCLES is the abort cycle.
  assign timeout_hit = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
`endif

  // State register.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) state <= S_IDLE;
    else        state <= state_nx;
  end

  // Next-state logic and grant/completion strobes.
  always_comb begin
    state_nx = state;
    grant_i  = 1'b0;
    grant_d  = 1'b0;
    capture  = 1'b0;
    abort    = 1'b0;
    case (state)
      S_IDLE: begin
        if (D_REQ && (!I_REQ || !last_d)) begin
          grant_d  = 1'b1;
          state_nx = S_WAIT;
        end else if (I_REQ) begin
          grant_i  = 1'b1;
          state_nx = S_WAIT;
        end
      end
      S_WAIT: begin
        if (MOC) begin
          capture  = 1'b1;
          state_nx = S_RESP;
        end
`ifdef MEM_TIMEOUT_EN
        // MOC takes priority over a coincident timeout.
        else if (timeout_hit) begin
          abort    = 1'b1;
          state_nx = S_RESP;
        end
`endif
      end
      S_RESP:    state_nx = S_RELEASE;
      S_RELEASE: if (!MOC) state_nx = S_IDLE;
      default:   state_nx = S_IDLE;
    endcase
  end

  // RAM-side operation registers, grant bookkeeping and read-data capture.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      gnt_d     <= 1'b0;
      last_d    <= 1'b0;
      mov_q     <= 1'b0;
      rw_q      <= 1'b0;
      ms_q      <= '0;
      din_q     <= '0;
      addr_q    <= '0;
      i_rdata_q <= '0;
      d_rdata_q <= '0;
    end else begin
      if (grant_i) begin
        gnt_d  <= 1'b0;
        last_d <= 1'b0;
        mov_q  <= 1'b1;
        rw_q   <= 1'b1;
        ms_q   <= FETCH_MS;
        din_q  <= '0;
        addr_q <= I_ADDR;
      end
      if (grant_d) begin
        gnt_d  <= 1'b1;
        last_d <= 1'b1;
        mov_q  <= 1'b1;
        rw_q   <= D_RW;
        ms_q   <= D_MS;
        din_q  <= D_WDATA;
        addr_q <= D_ADDR;
      end
      if (capture || abort) mov_q <= 1'b0;
      if (capture) begin
        if (!gnt_d)    i_rdata_q <= RAM_DOUT;
        else if (rw_q) d_rdata_q <= RAM_DOUT;
      end
      if (abort) begin
        if (!gnt_d)    i_rdata_q <= '0;
        else if (rw_q) d_rdata_q <= '0;
      end
    end
  end

`ifdef MEM_TIMEOUT_EN
  // Timeout counter: cleared on grant, counts WAIT cycles without MOC; err_q marks an aborted op.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      if (grant_i || grant_d) begin
        cnt_q <= '0;
        err_q <= 1'b0;
      end else if (state == S_WAIT && !MOC) begin
        cnt_q <= cnt_q + 1'b1;
      end
      if (abort) err_q <= 1'b1;
    end
  end

  assign ERR = (state == S_RESP) && err_q;
`else
  assign ERR = 1'b0;
`endif

  assign I_ACK     = (state == S_RESP) && !gnt_d;
  assign D_ACK     = (state == S_RESP) &&  gnt_d;
  assign I_RDATA   = i_rdata_q;
  assign D_RDATA   = d_rdata_q;
  assign MOV       = mov_q;
  assign ReadWrite = rw_q;
  assign MS_2_0    = ms_q;
  assign RAM_DIN   = din_q;
  assign RAM_ADDR  = addr_q;

endmodule
